// File: rtl/qed_dup_sched_if.sv
// Handshake bundle between the SQED fetch shim / environment and the QED duplicate sequencer.
// "master" drives the core-side requests; "slave" is the sequencer.
interface qed_dup_sched_if #(
  parameter int DEPTH = 16,
  parameter int CNT_W = $clog2(DEPTH) + 1
);
  localparam int AW = $clog2(DEPTH);

  logic             fetch_en;
  logic             exec_dup;
  logic             retire_valid;
  logic             sel_dup;
  logic             fetch_hold;
  logic             cache_wr;
  logic             cache_rd;
  logic [AW-1:0]    cache_addr;
  logic [1:0]       sif_state;
  logic [CNT_W-1:0] qed_num_orig;
  logic [CNT_W-1:0] qed_num_dup;
  logic             sif_commit;
  logic             sif_commit_pulsed;
  logic             qed_check_valid;

  modport master (
    output fetch_en, exec_dup, retire_valid,
    input  sel_dup, fetch_hold, cache_wr, cache_rd, cache_addr, sif_state,
           qed_num_orig, qed_num_dup, sif_commit, sif_commit_pulsed, qed_check_valid
  );

  modport slave (
    input  fetch_en, exec_dup, retire_valid,
    output sel_dup, fetch_hold, cache_wr, cache_rd, cache_addr, sif_state,
           qed_num_orig, qed_num_dup, sif_commit, sif_commit_pulsed, qed_check_valid
  );
endinterface

// File: rtl/qed_dup_sched.sv
// SQED sequencer: issues originals into the QED cache, replays them as duplicates,
// drains the pipeline and raises the commit / check-valid strobes for the formal checker.
module qed_dup_sched #(
  parameter int DEPTH  = 16,
  parameter int CNT_W  = $clog2(DEPTH) + 1,
  parameter int INFL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  qed_dup_sched_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [INFL_W-1:0] INFL_MAX  = '1;

  typedef enum logic [1:0] {
    ST_ORIG   = 2'd0,
    ST_DUP    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  num_orig;
  logic [CNT_W-1:0]  num_dup;
  logic [INFL_W-1:0] inflight;
  logic              sif_commit_q;
  logic              check_valid_q;
  // Counters still hold the previous window's final values until the next original.
  logic              stale;

  logic              hold;
  logic              accept;
  logic              fresh_accept;
  logic [CNT_W-1:0]  orig_next;
  logic [CNT_W-1:0]  dup_next;
  logic [CNT_W-1:0]  win_orig_next;
  logic [INFL_W-1:0] infl_next;

  // Reset gates accept so that no cache write leaks out while the block is held in reset.
  always_comb begin
    hold         = (state == ST_DRAIN) || (state == ST_COMMIT);
    accept       = bus.fetch_en & ~hold & ~rst;
    fresh_accept = (state == ST_ORIG) && accept && stale;
  end

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    orig_next = num_orig;
    dup_next  = num_dup;
    if (state == ST_ORIG && accept) begin
      if (stale) begin
        orig_next = CNT_W'(1);
        dup_next  = '0;
      end else begin
        orig_next = num_orig + CNT_W'(1);
      end
    end
    if (state == ST_DUP && accept) begin
      dup_next = num_dup + CNT_W'(1);
    end
    // A stale count does not belong to the open window, so it cannot trigger DUP.
    win_orig_next = (stale && !fresh_accept) ? '0 : orig_next;
  end

  always_comb begin
    infl_next = inflight;
    if (accept && !bus.retire_valid) begin
      if (inflight != INFL_MAX) infl_next = inflight + INFL_W'(1);
    end else if (!accept && bus.retire_valid && inflight != '0) begin
      infl_next = inflight - INFL_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking here would race other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_ORIG;
      num_orig      <= '0;
      num_dup       <= '0;
      inflight      <= '0;
      sif_commit_q  <= 1'b0;
      check_valid_q <= 1'b0;
      stale         <= 1'b0;
    end else begin
      num_orig <= orig_next;
      num_dup  <= dup_next;
      inflight <= infl_next;
      unique case (state)
        ST_ORIG: begin
          if (fresh_accept) begin
            stale         <= 1'b0;
            sif_commit_q  <= 1'b0;
            check_valid_q <= 1'b0;
          end
          if (win_orig_next == DEPTH_CNT ||
              (bus.exec_dup && win_orig_next != '0)) begin
            state <= ST_DUP;
          end
        end
        ST_DUP: begin
          if (dup_next == num_orig) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (infl_next == '0) state <= ST_COMMIT;
        end
        ST_COMMIT: begin
          sif_commit_q  <= 1'b1;
          check_valid_q <= (num_orig == num_dup) && (num_orig != '0);
          stale         <= 1'b1;
          state         <= ST_ORIG;
        end
        default: state <= ST_ORIG;
      endcase
    end
  end

  always_comb begin
    bus.sel_dup           = (state == ST_DUP) || (state == ST_DRAIN);
    bus.fetch_hold        = hold;
    bus.cache_wr          = (state == ST_ORIG) && accept;
    bus.cache_rd          = (state == ST_DUP) && accept;
    bus.sif_commit_pulsed = (state == ST_COMMIT);
    bus.cache_addr        = '0;
    if (state == ST_ORIG) begin
      bus.cache_addr = stale ? '0 : num_orig[AW-1:0];
    end else if (state == ST_DUP) begin
      bus.cache_addr = num_dup[AW-1:0];
    end
  end

  assign bus.sif_state       = state;
  assign bus.qed_num_orig    = num_orig;
  assign bus.qed_num_dup     = num_dup;
  assign bus.sif_commit      = sif_commit_q;
  assign bus.qed_check_valid = check_valid_q;
endmodule
